// File: rtl/ili9341_spi_tx.sv
// ili9341_spi_tx: FIFO-buffered SPI mode-0 byte transmitter (MSB first) driving ILI9341 CS/DC/SCK/MOSI.
// Define ILI9341_SPI_BYTECNT_EN to add the byte_count output (bytes fully shifted, wraps at 16 bits).
//
// state      | meaning
// IDLE       | CS high, waiting for a FIFO entry
// LOAD       | pop FIFO, load shifter, drive DC/CS/first MOSI bit
// SETUP      | SCK low, MOSI setup before first rising edge
// SHIFT_HI   | SCK high, panel samples MOSI
// SHIFT_LO   | SCK low, MOSI advances to next bit
// GAP        | CS high for the inter-burst idle time
module ili9341_spi_tx #(
    parameter int CLK_DIV        = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int CS_IDLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_dc,
    output logic        busy,
    output logic        spi_sck,
    output logic        spi_mosi,
    output logic        spi_dc,
    output logic        spi_cs
`ifdef ILI9341_SPI_BYTECNT_EN
    ,
    output logic [15:0] byte_count
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETUP, S_SHIFT_HI, S_SHIFT_LO, S_GAP
    } state_t;

    state_t      r_state, w_next;
    logic [8:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic        w_full, w_empty, w_push, w_pop;
    logic [8:0]  w_head;
    logic [15:0] r_tmr, w_tmr_init;
    logic        w_tmr_done;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_sck, r_mosi, r_dc, r_cs;
    logic        w_hi_to_lo, w_enter_gap, w_byte_done, w_sck_next;

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_push     = in_valid && !w_full;
    assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
    assign w_tmr_done = (r_tmr == '0);

    assign in_ready = !w_full;
    assign busy     = (r_state != S_IDLE) || !w_empty;
    assign spi_sck  = r_sck;
    assign spi_mosi = r_mosi;
    assign spi_dc   = r_dc;
    assign spi_cs   = r_cs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= {in_dc, in_data};
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (!w_empty) w_next = S_LOAD;
            S_LOAD:     w_next = S_SETUP;
            S_SETUP:    if (w_tmr_done) w_next = S_SHIFT_HI;
            S_SHIFT_HI: if (w_tmr_done) w_next = S_SHIFT_LO;
            S_SHIFT_LO: begin
                if (w_tmr_done) begin
                    if (r_bit != 3'd0)  w_next = S_SHIFT_HI;
                    else if (!w_empty)  w_next = S_LOAD;
                    else                w_next = S_GAP;
                end
            end
            S_GAP:      if (w_tmr_done) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_pop       = (r_state == S_LOAD);
        w_hi_to_lo  = (r_state == S_SHIFT_HI) && (w_next == S_SHIFT_LO);
        w_enter_gap = (r_state != S_GAP) && (w_next == S_GAP);
        w_byte_done = (r_state == S_SHIFT_LO) && w_tmr_done && (r_bit == 3'd0);
        w_sck_next  = (w_next == S_SHIFT_HI);
        w_tmr_init  = '0;
        case (w_next)
            S_SETUP, S_SHIFT_HI, S_SHIFT_LO: w_tmr_init = 16'(CLK_DIV - 1);
            S_GAP:                           w_tmr_init = 16'(CS_IDLE_CYCLES - 1);
            default:                         w_tmr_init = '0;
        endcase
    end

    // Phase timer reloads on every state change and counts down to the terminal count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmr <= '0;
        end else if (r_state != w_next) begin
            r_tmr <= w_tmr_init;
        end else if (!w_tmr_done) begin
            r_tmr <= r_tmr - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit   <= '0;
            r_shift <= '0;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
            r_dc    <= 1'b0;
            r_cs    <= 1'b1;
        end else begin
            r_sck <= w_sck_next;
            if (w_pop) begin
                r_shift <= w_head[7:0];
                r_dc    <= w_head[8];
                r_cs    <= 1'b0;
                r_mosi  <= w_head[7];
                r_bit   <= 3'd7;
            end else if (w_hi_to_lo) begin
                r_shift <= r_shift << 1;
                r_mosi  <= r_shift[6];
            end else if (w_enter_gap) begin
                r_cs    <= 1'b1;
                r_mosi  <= 1'b0;
            end
            if ((r_state == S_SHIFT_LO) && w_tmr_done && (r_bit != 3'd0)) r_bit <= r_bit - 3'd1;
        end
    end

`ifdef ILI9341_SPI_BYTECNT_EN
    logic [15:0] r_byte_count;
    assign byte_count = r_byte_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             r_byte_count <= '0;
        else if (w_byte_done) r_byte_count <= r_byte_count + 16'd1;
    end
`else
    logic w_unused;
    assign w_unused = w_byte_done;
`endif

endmodule

// File: doc/ili9341_spi_tx.md
Name: ili9341_spi_tx

Overview:
- Byte-level SPI transmitter that drives the ILI9341 panel pins. It sits directly downstream of the ILI9341 init/pixel controller inside ili9341_top.
- Accepts {dc, byte} words over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each word in SPI mode 0, MSB first, and manages chip-select and the D/C line.

Parameters:
- CLK_DIV, 4: system clocks per SCK half-period; must be >= 1.
- FIFO_DEPTH, 4: entries of {dc, data}; must be a power of 2, >= 2.
- CS_IDLE_CYCLES, 2: clocks CS is held high after a burst ends; must be >= 1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  FIFO not full; combinational, equal to !full.
- in_data  in  8  byte to send.
- in_dc  in  1  0 = command, 1 = data/parameter.
- busy  out  1  high when the FSM is not in IDLE or the FIFO is non-empty.
- spi_sck  out  1  serial clock; idles low.
- spi_mosi  out  1  serial data.
- spi_dc  out  1  D/C pin driven to the panel.
- spi_cs  out  1  chip select, active-low.

Behaviour:
- Reset (rst=0, asynchronous):
  - spi_cs=1, spi_sck=0, spi_mosi=0, spi_dc=0, busy=0, in_ready=1.
  - FIFO flushed, FSM in IDLE, all counters cleared.
  - Reset asserted mid-byte aborts the byte immediately; there is no partial completion.
- Push: a word is written when in_valid && in_ready on a rising edge. When the FIFO is full, in_ready=0 and the word is not written. Push and pop in the same cycle are both honoured.
- FSM states: IDLE, LOAD, SETUP, SHIFT_HI, SHIFT_LO, GAP.
  - IDLE: when the FIFO is non-empty, go to LOAD.
  - LOAD (1 clk): pop the FIFO; shift register <= data; spi_dc <= dc; spi_cs <= 0; spi_mosi <= data[7]; bit counter <= 7. Then go to SETUP.
  - SETUP (CLK_DIV clks): sck stays low, giving data setup time. Then go to SHIFT_HI.
  - SHIFT_HI (CLK_DIV clks): spi_sck=1; the panel samples MOSI. Then go to SHIFT_LO.
  - SHIFT_LO (CLK_DIV clks): spi_sck=0. spi_mosi updates to the next bit on the first cycle of this state. If bits remain, go back to SHIFT_HI. After bit 0: go to LOAD if the FIFO is non-empty (CS stays low), otherwise go to GAP.
  - GAP (CS_IDLE_CYCLES clks): spi_cs=1, spi_mosi=0. Then go to IDLE. New words arriving during GAP wait until the gap completes.
- Timing:
  - Byte period, accept-to-next-LOAD for back-to-back bytes: 1 + 17*CLK_DIV clks (69 at default).
  - Rising SCK edges within a byte are spaced 2*CLK_DIV clks.
  - Latency: with an empty FIFO and IDLE, a push on edge N gives LOAD on edge N+1 and spi_cs low after edge N+2.
- spi_dc changes only in LOAD, while sck=0. It is stable for the whole byte.
- All SPI outputs are registered (glitch-free).

Optional Feature:
- Macro: ILI9341_SPI_BYTECNT_EN.
- Defined: adds output port byte_count [15:0], reset to 0. It increments by 1 at the end of each byte's final SHIFT_LO and wraps 65535 -> 0.
- Undefined: the port and its counter are absent; behaviour is otherwise identical.

Test Plan:
1. Hold rst=0 for 5 clks while in_valid=1 -> spi_cs=1, spi_sck=0, spi_mosi=0, spi_dc=0, busy=0 throughout. After release, in_ready=1.
2. Push 0x2A, dc=0 (CLK_DIV=4):
   - MOSI sampled at 8 rising SCK edges reads 0,0,1,0,1,0,1,0.
   - Edges are 8 clks apart; spi_dc=0 while CS is low.
   - CS rises 68 clks after LOAD; busy falls after a 2-clk gap.
3. Push 5 words in consecutive cycles while IDLE:
   - in_ready holds and all 5 are accepted, because the first pop frees a slot.
   - CS stays low across all 40 SCK rising edges.
   - LOADs are 69 clks apart and byte order is preserved.
4. Hold the FSM busy and fill the FIFO to 4 -> in_ready=0. A 5th push is ignored, and exactly 4 bytes are later transmitted.
5. Push 0x2C dc=0, then 0x1F dc=1 -> spi_dc goes 0 -> 1 at the second LOAD, with sck=0 at the change. The second byte's MOSI reads 0,0,0,1,1,1,1,1.
6. Assert rst after 3 SCK edges of 0xFF -> outputs return to reset values immediately. After release, push 0x55 -> MOSI reads 0,1,0,1,0,1,0,1. With ILI9341_SPI_BYTECNT_EN, byte_count=1.
